gps_cmd_tx: RTL and testbench

UART transmitter for the GPS module's command direction: it frames a caller-supplied ASCII payload as an NMEA/PMTK sentence and shifts it out at 9600 baud, 8N1. The frame is `$`, then the payload, then `*`, two uppercase hex checksum characters, CR and LF. It is the send-side counterpart of the GPS receive path and drives the module's RX pin. The checksum is the XOR of all payload bytes, computed on the fly.

---
 rtl/gps_cmd_tx_pkg.sv | 28 ++
 rtl/gps_cmd_tx_if.sv | 25 ++
 rtl/gps_cmd_tx_uart_send_9600.sv | 74 +++++++
 rtl/gps_cmd_tx.sv | 172 +++++++++++++++++
 tb/tb_gps_cmd_tx.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_cmd_tx_pkg.sv
// Shared constants, FSM encodings and sizing helpers for the GPS command transmitter.
package gps_cmd_tx_pkg;

    localparam int unsigned MAX_LEN_DEF = 48;
    localparam int unsigned FRAME_BITS  = 10;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DOLLAR = 3'd1,
        ST_BODY   = 3'd2,
        ST_STAR   = 3'd3,
        ST_CK_HI  = 3'd4,
        ST_CK_LO  = 3'd5,
        ST_CR     = 3'd6,
        ST_LF     = 3'd7
    } state_t;

    // Clock cycles per serial bit (integer division).
    function automatic int unsigned bit_cycles(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/gps_cmd_tx_if.sv
// Command request / serial line bundle between the host logic and gps_cmd_tx.
interface gps_cmd_tx_if
    import gps_cmd_tx_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic                   start;
    logic [MAX_LEN*8-1:0]   payload;
    logic [LEN_W-1:0]       len;
    logic                   data_tx;
    logic                   busy;
    logic                   done;

    modport master (
        output start, payload, len,
        input  data_tx, busy, done
    );

    modport slave (
        input  start, payload, len,
        output data_tx, busy, done
    );
endinterface

// File: rtl/gps_cmd_tx_uart_send_9600.sv
// 8N1 bit serializer: start bit, 8 data bits LSB first, one stop bit.
// ready_c_o is high while idle and during the final cycle of a stop bit,
// so a byte loaded then starts with no idle gap.
module gps_cmd_tx_uart_send_9600
    import gps_cmd_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       load_i,
    output logic       data_tx_o,
    output logic       ready_c_o
);
    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  active_q, active_d;
    logic                  bit_end_c;
    logic                  last_c;

    assign bit_end_c = (cnt_q == CNT_W'(BIT_CYCLES - 1));
    assign last_c    = active_q && bit_end_c && (idx_q == 4'(FRAME_BITS - 1));
    assign ready_c_o = !active_q || last_c;

    // Line is the LSB of the frame shifter; ones shift in so it idles high.
    assign data_tx_o = frame_q[0];

    // Next bit counter / bit index / shifter values.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        frame_d  = frame_q;
        active_d = active_q;
        if (load_i && ready_c_o) begin
            frame_d  = {1'b1, byte_i, 1'b0};
            cnt_d    = '0;
            idx_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (bit_end_c) begin
                cnt_d   = '0;
                frame_d = {1'b1, frame_q[FRAME_BITS-1:1]};
                if (idx_q == 4'(FRAME_BITS - 1)) begin
                    idx_d    = '0;
                    active_d = 1'b0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Serializer registers; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            frame_q  <= '1;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/gps_cmd_tx.sv
// NMEA/PMTK sentence transmitter: frames "$<payload>*HH\r\n" onto the GPS RX line.
// Each byte state loads its own character once, then on the serializer's
// final stop-bit cycle moves on and loads the next character in the same cycle.
module gps_cmd_tx
    import gps_cmd_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BAUD    = 9600,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    gps_cmd_tx_if.slave bus
);
    localparam int unsigned BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [MAX_LEN-1:0][7:0] pay_q, pay_d;
    logic [7:0]              ck_q, ck_d;
    logic                    loaded_q, loaded_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    len_ok_c;
    logic                    accept_c;
    logic                    first_c;
    logic                    adv_c;
    logic                    load_c;
    logic                    ser_ready_c;
    logic                    ser_tx_c;
    logic [IDX_W-1:0]        sel_c;
    logic [7:0]              body_byte_c;
    logic [7:0]              tx_byte_c;

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    assign len_ok_c = (bus.len != '0) && (bus.len <= LEN_W'(MAX_LEN));
    assign accept_c = (state_q == ST_IDLE) && bus.start && len_ok_c;
    assign first_c  = (state_q != ST_IDLE) && !loaded_q && ser_ready_c;
    assign adv_c    = (state_q != ST_IDLE) && loaded_q && ser_ready_c;

    // State register: byte state and payload byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: advance when the current byte finishes its stop bit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_DOLLAR;
                    idx_d   = '0;
                end
            end
            ST_DOLLAR: begin
                if (adv_c) begin
                    state_d = ST_BODY;
                    idx_d   = '0;
                end
            end
            ST_BODY: begin
                if (adv_c) begin
                    if (idx_q == IDX_W'(len_q - LEN_W'(1))) begin
                        state_d = ST_STAR;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STAR:  if (adv_c) state_d = ST_CK_HI;
            ST_CK_HI: if (adv_c) state_d = ST_CK_LO;
            ST_CK_LO: if (adv_c) state_d = ST_CR;
            ST_CR:    if (adv_c) state_d = ST_LF;
            ST_LF:    if (adv_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: serializer load, character select, latch/checksum updates.
    always_comb begin
        load_c      = first_c || (adv_c && (state_q != ST_LF));
        sel_c       = IDX_W'(MAX_LEN - 1) - idx_d;
        body_byte_c = pay_q[sel_c];
        tx_byte_c   = 8'h00;
        len_d       = len_q;
        pay_d       = pay_q;
        ck_d        = ck_q;
        loaded_d    = loaded_q;
        busy_d      = (state_d != ST_IDLE);
        done_d      = adv_c && (state_q == ST_LF);

        case (state_d)
            ST_DOLLAR: tx_byte_c = CH_DOLLAR;
            ST_BODY:   tx_byte_c = body_byte_c;
            ST_STAR:   tx_byte_c = CH_STAR;
            ST_CK_HI:  tx_byte_c = hex_ascii(ck_q[7:4]);
            ST_CK_LO:  tx_byte_c = hex_ascii(ck_q[3:0]);
            ST_CR:     tx_byte_c = CH_CR;
            ST_LF:     tx_byte_c = CH_LF;
            default:   tx_byte_c = 8'h00;
        endcase

        if (accept_c) begin
            len_d    = bus.len;
            pay_d    = bus.payload;
            ck_d     = '0;
            loaded_d = 1'b0;
        end else if (state_d == ST_IDLE) begin
            loaded_d = 1'b0;
        end else if (load_c) begin
            loaded_d = 1'b1;
        end

        if (load_c && (state_d == ST_BODY)) begin
            ck_d = ck_q ^ body_byte_c;
        end
    end

    // Datapath registers: latched request, checksum, status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            pay_q    <= '0;
            ck_q     <= '0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            len_q    <= len_d;
            pay_q    <= pay_d;
            ck_q     <= ck_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    gps_cmd_tx_uart_send_9600 #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_i    (tx_byte_c),
        .load_i    (load_c),
        .data_tx_o (ser_tx_c),
        .ready_c_o (ser_ready_c)
    );

    assign bus.data_tx = ser_tx_c;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_gps_cmd_tx.sv
// Directed bench for gps_cmd_tx with a scaled bit time (10 cycles per bit).
module tb_gps_cmd_tx;

    localparam int BC = 10;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vec;
    int   err;
    int   done_cnt;
    int   busy_cnt;
    int   stop_err;

    logic [7:0] rx_q[$];
    int         edge_q[$];
    logic       prev_tx;
    bit         rx_act;
    int         rx_cnt;
    logic [7:0] rx_sh;

    gps_cmd_tx_if #(.MAX_LEN(48)) bus ();

    gps_cmd_tx #(
        .CLK_HZ  (96_000),
        .BAUD    (9_600),
        .MAX_LEN (48)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line monitor: edge timestamps, 8N1 decoding, done/busy counters.
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        if (!rst_n) begin
            rx_act  = 1'b0;
            rx_cnt  = 0;
            prev_tx = 1'b1;
        end else begin
            if (bus.data_tx !== prev_tx) edge_q.push_back(cyc);
            prev_tx = bus.data_tx;
            if (!rx_act) begin
                if (bus.data_tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= BC + BC/2 && ((rx_cnt - BC/2) % BC) == 0) begin
                    if ((rx_cnt - BC/2) / BC == 9) begin
                        if (bus.data_tx !== 1'b1) stop_err++;
                        rx_q.push_back(rx_sh);
                        rx_act = 1'b0;
                    end else begin
                        rx_sh = {bus.data_tx, rx_sh[7:1]};
                    end
                end
            end
        end
    end

    function automatic logic [383:0] pack(input string s);
        logic [383:0] p;
        p = '0;
        for (int k = 0; k < s.len(); k++) p[383-8*k -: 8] = s[k];
        return p;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        edge_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        stop_err = 0;
    endtask

    task automatic pulse_start(input logic [383:0] p, input logic [5:0] l);
        @(negedge clk);
        bus.payload = p;
        bus.len     = l;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vec++; if (bus.data_tx !== 1'b1) begin err++; $display("FAIL reset_tx: got %b want 1", bus.data_tx); end
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vec++; if (bus.done !== 1'b0) begin err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vec++; if (bus.data_tx !== 1'b1 || bus.busy !== 1'b0) begin
            err++; $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", bus.data_tx, bus.busy);
        end
    endtask

    task automatic test_single_a();
        bit    ok;
        string exp_s = "$A*41\r\n";
        clear_mon();
        @(negedge clk);
        bus.payload = pack("A");
        bus.len     = 6'd1;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL single_busy_rise: got %b want 1", bus.busy); end
        vec++; if (bus.data_tx !== 1'b1) begin err++; $display("FAIL single_tx_latency1: got %b want 1", bus.data_tx); end
        @(posedge clk); #1;
        vec++; if (bus.data_tx !== 1'b0) begin err++; $display("FAIL single_start_bit: got %b want 0", bus.data_tx); end
        wait_done(70*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL single_done_timeout: got no done want done"); end
        repeat (30) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL single_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL single_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
        vec++; if (done_cnt != 1) begin err++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
        vec++; if (busy_cnt < 70*BC || busy_cnt > 70*BC + 1) begin
            err++; $display("FAIL single_busy_width: got %0d want %0d..%0d", busy_cnt, 70*BC, 70*BC + 1);
        end
        vec++; if (stop_err != 0) begin err++; $display("FAIL single_stop_bits: got %0d want 0", stop_err); end
    endtask

    task automatic test_pmtk();
        bit    ok;
        string exp_s = "$PMTK220,1000*1F\r\n";
        clear_mon();
        pulse_start(pack("PMTK220,1000"), 6'd12);
        wait_done(18*10*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL pmtk_done_timeout: got no done want done"); end
        repeat (30) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL pmtk_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL pmtk_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
    endtask

    task automatic test_bit_timing();
        bit ok;
        int exp_off[17];
        exp_off = '{0, 3, 4, 6, 7, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20};
        clear_mon();
        pulse_start(pack("U"), 6'd1);
        wait_done(70*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL timing_done_timeout: got no done want done"); end
        vec++; if (edge_q.size() < 17) begin err++; $display("FAIL timing_edge_count: got %0d want >=17", edge_q.size()); end
        for (int i = 1; i < 17 && i < edge_q.size(); i++) begin
            vec++; if (edge_q[i] - edge_q[0] != exp_off[i]*BC) begin
                err++; $display("FAIL timing_edge%0d: got %0d want %0d", i, edge_q[i] - edge_q[0], exp_off[i]*BC);
            end
        end
    endtask

    task automatic test_max_len();
        bit    ok;
        string body  = "0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF";
        string exp_s = {"$", body, "*06\r\n"};
        clear_mon();
        pulse_start(pack(body), 6'd48);
        wait_done(54*10*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL maxlen_done_timeout: got no done want done"); end
        repeat (30) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL maxlen_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL maxlen_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
    endtask

    task automatic test_invalid_len();
        clear_mon();
        pulse_start(pack("A"), 6'd0);
        repeat (1000) @(negedge clk);
        pulse_start(pack("A"), 6'd49);
        repeat (1000) @(negedge clk);
        vec++; if (busy_cnt != 0) begin err++; $display("FAIL invalid_busy: got %0d busy cycles want 0", busy_cnt); end
        vec++; if (done_cnt != 0) begin err++; $display("FAIL invalid_done: got %0d want 0", done_cnt); end
        vec++; if (edge_q.size() != 0) begin err++; $display("FAIL invalid_line: got %0d edges want 0", edge_q.size()); end
    endtask

    task automatic test_busy_ignore();
        bit    ok;
        string exp_s = "$ABC*40\r\n";
        clear_mon();
        pulse_start(pack("ABC"), 6'd3);
        bus.payload = pack("ZZZZZ");
        bus.len     = 6'd5;
        repeat (35*BC) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(9*10*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL ignore_done_timeout: got no done want done"); end
        bus.len = 6'd0;
        repeat (30*BC) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL ignore_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL ignore_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
        vec++; if (done_cnt != 1) begin err++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL ignore_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        bit    ok;
        string exp_s = "$A*41\r\n$B*42\r\n";
        clear_mon();
        pulse_start(pack("A"), 6'd1);
        wait_done(70*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL b2b_first_timeout: got no done want done"); end
        bus.payload = pack("B");
        bus.len     = 6'd1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        vec++; if (bus.busy !== 1'b1) begin err++; $display("FAIL b2b_accept: got busy=%b want 1", bus.busy); end
        wait_done(70*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL b2b_second_timeout: got no done want done"); end
        repeat (30) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL b2b_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
        vec++; if (done_cnt != 2) begin err++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit    ok;
        bit    low_seen;
        string exp_s = "$A*41\r\n";
        clear_mon();
        pulse_start(pack("ABC"), 6'd3);
        repeat (12*BC) @(negedge clk);
        low_seen = 1'b0;
        for (int i = 0; i < 20*BC; i++) begin
            if (bus.data_tx === 1'b0) begin
                low_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vec++; if (!low_seen) begin err++; $display("FAIL midreset_low_timeout: got no low bit want low bit"); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (bus.data_tx !== 1'b1) begin err++; $display("FAIL midreset_tx: got %b want 1", bus.data_tx); end
        vec++; if (bus.busy !== 1'b0) begin err++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20*BC) @(negedge clk);
        vec++; if (done_cnt != 0) begin err++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt); end
        clear_mon();
        pulse_start(pack("A"), 6'd1);
        wait_done(70*BC + 50, ok);
        vec++; if (!ok) begin err++; $display("FAIL midreset_resend_timeout: got no done want done"); end
        repeat (30) @(negedge clk);
        vec++; if (rx_q.size() != exp_s.len()) begin err++; $display("FAIL midreset_len: got %0d want %0d", rx_q.size(), exp_s.len()); end
        for (int i = 0; i < exp_s.len() && i < rx_q.size(); i++) begin
            vec++; if (rx_q[i] !== exp_s[i]) begin err++; $display("FAIL midreset_byte%0d: got %02h want %02h", i, rx_q[i], exp_s[i]); end
        end
    endtask

    initial begin
        vec         = 0;
        err         = 0;
        cyc         = 0;
        done_cnt    = 0;
        busy_cnt    = 0;
        stop_err    = 0;
        prev_tx     = 1'b1;
        rx_act      = 1'b0;
        rx_cnt      = 0;
        rx_sh       = 8'h00;
        bus.start   = 1'b0;
        bus.payload = '0;
        bus.len     = '0;

        test_reset();
        test_single_a();
        test_pmtk();
        test_bit_timing();
        test_max_len();
        test_invalid_len();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
